// File: rtl/fft_power_reorder_if.sv
// fft_power_reorder_if: FFT bin input stream and natural-order power output stream.
interface fft_power_reorder_if #(
  parameter int N = 1024,
  parameter int WIDTH = 14,
  parameter int PW = 2 * WIDTH
);
  localparam int LOG_N = $clog2(N);
  logic di_en;
  logic signed [WIDTH-1:0] di_re;
  logic signed [WIDTH-1:0] di_im;
  logic do_valid;
  logic do_ready;
  logic [LOG_N-1:0] do_bin;
  logic [PW-1:0] do_pow;
  logic do_last;
  logic overflow;
  logic frame_err;
  modport master(
    output di_en, di_re, di_im, do_ready,
    input do_valid, do_bin, do_pow, do_last, overflow, frame_err
  );
  modport slave(
    input di_en, di_re, di_im, do_ready,
    output do_valid, do_bin, do_pow, do_last, overflow, frame_err
  );
endinterface

// File: rtl/fft_power_reorder.sv
// fft_power_reorder: bin power of a bit-reversed FFT stream, reordered through
// a ping-pong buffer and streamed out as natural-order bins 0..N/2.
module fft_power_reorder #(
  parameter int N = 1024,
  parameter int WIDTH = 14,
  parameter int PW = 2 * WIDTH
) (
  input logic clock,
  input logic reset,
  fft_power_reorder_if.slave bus
);
  localparam int LOG_N = $clog2(N);
  localparam int PWI = 2 * WIDTH;
  localparam int SW = PWI + 1;
  localparam int DEPTH = N / 2 + 1;
  localparam logic [LOG_N-1:0] HALF = LOG_N'(N / 2);
  localparam logic [LOG_N-1:0] LAST = LOG_N'(N - 1);
  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_t;
  bank_t r_st [2];
  bank_t w_st [2];
  logic [LOG_N-1:0] r_in_cnt, w_waddr, r_s1_addr, r_s2_addr, r_rd_addr;
  logic r_tgt, r_cur, r_active, r_s1_v, r_s1_bank, r_s1_last, r_s2_v, r_s2_bank, r_s2_last;
  logic r_rd_act, r_rd_bank, r_rd_next, r_out_bank;
  logic signed [PWI-1:0] w_re_x, w_im_x, r_s1_rr, r_s1_ii;
  logic [SW-1:0] w_sum;
  logic [PW-1:0] w_pow, r_s2_pow;
  logic w_start, w_accept, w_wr0, w_wbank, w_abort, w_select, w_load, w_done;
  logic [1:0] w_m_fill, w_m_abort, w_m_full, w_m_sel, w_m_done;
  logic [PW-1:0] r_mem [2][DEPTH];
  function automatic logic [1:0] oh(input logic v, input logic b);
    return {v && b, v && !b};
  endfunction
  always_comb begin
    w_waddr = '0;
    for (int i = 0; i < LOG_N; i++) w_waddr[i] = r_in_cnt[LOG_N-1-i];
  end
  assign w_start = bus.di_en && r_in_cnt == '0;
  assign w_accept = r_st[r_tgt] == EMPTY;
  assign w_wr0 = bus.di_en && (w_start ? w_accept : r_active);
  assign w_wbank = w_start ? r_tgt : r_cur;
  assign w_abort = !bus.di_en && r_in_cnt != '0;
  assign w_re_x = PWI'(bus.di_re);
  assign w_im_x = PWI'(bus.di_im);
  assign w_sum = {1'b0, r_s1_rr} + {1'b0, r_s1_ii};
  assign w_pow = (w_sum >> PW) != '0 ? '1 : PW'(w_sum);
  assign w_select = !r_rd_act && r_st[r_rd_next] == FULL;
  assign w_load = r_rd_act && (!bus.do_valid || bus.do_ready);
  assign w_done = bus.do_valid && bus.do_ready && bus.do_last;
  assign bus.overflow = w_start && !w_accept;
  assign w_m_fill = oh(w_start && w_accept, r_tgt);
  assign w_m_abort = oh(w_abort && r_active, r_cur);
  assign w_m_full = oh(r_s2_v && r_s2_last, r_s2_bank);
  assign w_m_sel = oh(w_select, r_rd_next);
  assign w_m_done = oh(w_done, r_out_bank);
  always_comb begin
    w_st = r_st;
    for (int b = 0; b < 2; b++) begin
      if (w_m_fill[b]) w_st[b] = FILLING;
      if (w_m_abort[b]) w_st[b] = EMPTY;
      if (w_m_full[b]) w_st[b] = FULL;
      if (w_m_sel[b]) w_st[b] = DRAINING;
      if (w_m_done[b]) w_st[b] = EMPTY;
    end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_st <= '{EMPTY, EMPTY};
      r_in_cnt <= '0;
      r_tgt <= 1'b0;
      r_cur <= 1'b0;
      r_active <= 1'b0;
      r_s1_v <= 1'b0;
      r_s1_bank <= 1'b0;
      r_s1_addr <= '0;
      r_s1_last <= 1'b0;
      r_s1_rr <= '0;
      r_s1_ii <= '0;
      r_s2_v <= 1'b0;
      r_s2_bank <= 1'b0;
      r_s2_addr <= '0;
      r_s2_last <= 1'b0;
      r_s2_pow <= '0;
      r_rd_act <= 1'b0;
      r_rd_bank <= 1'b0;
      r_rd_next <= 1'b0;
      r_rd_addr <= '0;
      r_out_bank <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.do_valid <= 1'b0;
      bus.do_bin <= '0;
      bus.do_pow <= '0;
      bus.do_last <= 1'b0;
    end else begin
      r_st <= w_st;
      r_in_cnt <= bus.di_en ? r_in_cnt + 1'b1 : '0;
      if (w_start) begin
        r_active <= w_accept;
        if (w_accept) begin
          r_cur <= r_tgt;
          r_tgt <= !r_tgt;
        end
      end else if (w_abort) begin
        r_active <= 1'b0;
        if (r_active) r_tgt <= r_cur;
      end
      bus.frame_err <= w_abort;
      r_s1_v <= w_wr0;
      r_s1_bank <= w_wbank;
      r_s1_addr <= w_waddr;
      r_s1_last <= r_in_cnt == LAST;
      r_s1_rr <= w_re_x * w_re_x;
      r_s1_ii <= w_im_x * w_im_x;
      r_s2_v <= r_s1_v;
      r_s2_bank <= r_s1_bank;
      r_s2_addr <= r_s1_addr;
      r_s2_last <= r_s1_last;
      r_s2_pow <= w_pow;
      if (w_select) begin
        r_rd_act <= 1'b1;
        r_rd_bank <= r_rd_next;
        r_rd_next <= !r_rd_next;
        r_rd_addr <= '0;
      end else if (w_load) begin
        r_rd_addr <= r_rd_addr + 1'b1;
        if (r_rd_addr == HALF) r_rd_act <= 1'b0;
      end
      if (w_load) begin
        bus.do_valid <= 1'b1;
        bus.do_bin <= r_rd_addr;
        bus.do_pow <= r_mem[r_rd_bank][r_rd_addr];
        bus.do_last <= r_rd_addr == HALF;
        r_out_bank <= r_rd_bank;
      end else if (bus.do_ready) begin
        bus.do_valid <= 1'b0;
      end
    end
  end
  // Bins above N/2 are mirror images and never stored.
  always_ff @(posedge clock) begin
    if (r_s2_v && r_s2_addr <= HALF) r_mem[r_s2_bank][r_s2_addr] <= r_s2_pow;
  end
endmodule
